bus_arbiter_mux: RTL and testbench
==================================

# bus_arbiter_mux

Parametrised, registered successor to the datapath bus multiplexer: NSRC sources of WIDTH bits compete for a single shared bus through request lines, and a round-robin arbiter with a bounded hold time picks the owner. The owner's data is registered onto the bus. A legacy force-select path lets the control unit drive an encoded select directly, as the combinational mux did. The block sits between the register file, special registers and the ALU/memory inputs in the CPU datapath.

## Interface
- WIDTH, 32: bus data width in bits.
- NSRC, 26: number of bus sources; must be at least 2.
- SELW, $clog2(NSRC): width of the encoded select and the grant index.
- MAX_HOLD, 8: maximum number of consecutive cycles an unlocked owner may hold the bus while others are requesting. 0 means unlimited.
- clock  in  1  rising-edge clock; the only clock.
- clear_n  in  1  asynchronous, active-low reset.
- src_data  in  NSRC*WIDTH  flattened source buses; source i occupies bits [i*WIDTH +: WIDTH].
- req  in  NSRC  per-source bus request.
- lock  in  1  while high, the current owner is never pre-empted by MAX_HOLD.
- force_en  in  1  legacy direct-select override.
- force_sel  in  SELW  encoded source index used when force_en=1.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_out carries a granted or forced source.
- grant  out  NSRC  one-hot registered grant; all zero when idle.
- grant_idx  out  SELW  encoded owner; 0 when idle.

## Operation
- States: IDLE, OWNED, FORCED. All state and outputs are registered and update on the rising edge of clock.
- Reset (clear_n=0, asynchronous):
  - state=IDLE.
  - bus_out=0, bus_valid=0, grant=0, grant_idx=0.
  - hold_cnt=0.
  - last pointer=NSRC-1, so the first search starts at source 0.
- Evaluation at each edge, highest priority first:
  1. force_en=1: state goes to FORCED.
     - If force_sel<NSRC: grant=onehot(force_sel), grant_idx=force_sel, bus_out=src_data[force_sel], bus_valid=1.
     - Otherwise: grant=0, grant_idx=0, bus_out=0, bus_valid=0.
     - req is ignored. The last pointer and hold_cnt are unchanged.
  2. state=OWNED and req[owner]=1, with either no pre-emption condition or lock=1: keep the owner, bus_out=src_data[owner], hold_cnt+=1 (saturating at MAX_HOLD).
     - Pre-emption condition: MAX_HOLD≠0, hold_cnt≥MAX_HOLD, and some other req bit is set.
  3. Otherwise, arbitrate among the set req bits, searching from (last+1) mod NSRC with wrap-around. The winner w gives:
     - state=OWNED, grant=onehot(w), grant_idx=w, bus_out=src_data[w], bus_valid=1, hold_cnt=1, last=w.
     - If no req bit is set: state=IDLE with all outputs zero.
- Pre-empted owner: the search starts after it, so any other requester wins. If the owner is the sole requester, it re-wins and hold_cnt restarts at 1.
- Leaving FORCED: arbitration resumes under rule 3 using the preserved last pointer.

## Timing
- Latency is 1 cycle from req/force_en sampled high to a matching grant and bus_out.
- bus_out tracks the owner's src_data with 1-cycle delay for every cycle of ownership.
- Dropping req[owner] releases the bus at the next edge. Another requester can be granted on that same edge, so there is no dead cycle.
- Simultaneous force_en with an owner change: force wins. The pending arbitration is discarded, not queued.
- clear_n asserted mid-ownership: outputs are zero immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- Fairness: with all NSRC requests held high and lock=0, each source is granted once per NSRC*MAX_HOLD cycles.

## Structure
- Shared package bus_pkg holds:
  - the state enum (IDLE, OWNED, FORCED);
  - default WIDTH/NSRC;
  - legacy source-code constants: R0–R15=0–15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, OUTPORT=23, YREG=24, CREG=25.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req, last, exclude-mask.
  - Outputs: winner index and an any-request flag.
  - Parametrised on NSRC.
- Top level holds the FSM, hold counter, pointer and output registers.

## Test plan
- Reset then idle: req=0 → bus_valid=0, grant=0, bus_out=0. Then req[3]=1 with src3=0xDEADBEEF → next edge grant_idx=3, bus_out=0xDEADBEEF, bus_valid=1.
- Round-robin, all requesting, MAX_HOLD=2, lock=0 → grant_idx sequence 0,0,1,1,2,2,…,25,25,0 with no idle cycles.
- Lock: owner 5, lock=1, req[6]=1 held for 20 cycles → grant stays 5. Lock drops at hold_cnt=8 → next edge grant_idx=6.
- Handover: owner 2 drops req on the same edge req[7] rises → next edge grant_idx=7, bus_valid never deasserts.
- Force: force_en=1, force_sel=20 (PC=0x00000100) during ownership by 4 → next edge bus_out=0x100, grant_idx=20. force_sel=30 → bus_valid=0, bus_out=0. Release with only req[4]=1 → grant_idx=4.
- Asynchronous clear between clock edges while owned → bus_out, grant and bus_valid are zero immediately. After release, first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the registered datapath bus arbiter/mux.
// Source codes keep the numbering of the old combinational bus mux.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWNED  = 2'd1,
        FORCED = 2'd2
    } bus_state_e;

    localparam int BUS_WIDTH = 32;
    localparam int BUS_NSRC  = 26;

    localparam int R0  = 0,  R1  = 1,  R2  = 2,  R3  = 3;
    localparam int R4  = 4,  R5  = 5,  R6  = 6,  R7  = 7;
    localparam int R8  = 8,  R9  = 9,  R10 = 10, R11 = 11;
    localparam int R12 = 12, R13 = 13, R14 = 14, R15 = 15;
    localparam int HI      = 16;
    localparam int LO      = 17;
    localparam int ZHI     = 18;
    localparam int ZLO     = 19;
    localparam int PC      = 20;
    localparam int MDR     = 21;
    localparam int INPORT  = 22;
    localparam int OUTPORT = 23;
    localparam int YREG    = 24;
    localparam int CREG    = 25;

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Bus request/grant bundle between the datapath sources and the arbiter.
// master = sources/control unit, slave = the arbiter itself.
interface bus_arbiter_mux_if
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = BUS_NSRC,
    parameter int SELW  = $clog2(NSRC)
);
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       req;
    logic                  lock;
    logic                  force_en;
    logic [SELW-1:0]       force_sel;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [NSRC-1:0]       grant;
    logic [SELW-1:0]       grant_idx;

    modport master (
        output src_data, req, lock, force_en, force_sel,
        input  bus_out, bus_valid, grant, grant_idx
    );

    modport slave (
        input  src_data, req, lock, force_en, force_sel,
        output bus_out, bus_valid, grant, grant_idx
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after i_last,
// wrapping around, with masked-out sources skipped.
module rr_arbiter #(
    parameter int NSRC = 26,
    parameter int SELW = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] i_req,
    input  logic [SELW-1:0] i_last,
    input  logic [NSRC-1:0] i_excl,
    output logic [SELW-1:0] o_idx,
    output logic            o_any
);
    logic [NSRC-1:0] w_req;
    logic [SELW-1:0] w_p;

    assign w_req = i_req & ~i_excl;

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_p   = i_last;
        for (int k = 0; k < NSRC; k++) begin
            w_p = (w_p == SELW'(NSRC - 1)) ? '0 : w_p + 1'b1;
            if (!o_any && w_req[w_p]) begin
                o_any = 1'b1;
                o_idx = w_p;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus arbiter/mux: round-robin with bounded hold,
// owner lock, and the legacy encoded force-select override.
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter int WIDTH    = BUS_WIDTH,
    parameter int NSRC     = BUS_NSRC,
    parameter int SELW     = $clog2(NSRC),
    parameter int MAX_HOLD = 8
) (
    input  logic               clock,
    input  logic               clear_n,
    bus_arbiter_mux_if.slave   bus
);
    localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [SELW:0]  LP_NSRC = NSRC[SELW:0];
    localparam logic [HCW-1:0] LP_HMAX = MAX_HOLD[HCW-1:0];
    // With no hold limit the counter only needs to stay bounded.
    localparam logic [HCW-1:0] LP_HSAT = (MAX_HOLD == 0) ? '1 : LP_HMAX;

    bus_state_e       r_state, w_state;
    logic [WIDTH-1:0] r_bus, w_bus;
    logic             r_valid, w_valid;
    logic [NSRC-1:0]  r_grant, w_grant;
    logic [SELW-1:0]  r_idx, w_idx;
    logic [SELW-1:0]  r_last, w_last;
    logic [HCW-1:0]   r_hold, w_hold;

    logic [WIDTH-1:0] w_src [NSRC];
    logic [SELW-1:0]  w_win;
    logic             w_any;
    logic             w_fsel_ok;
    logic             w_others;
    logic             w_preempt;
    logic             w_keep;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign w_src[g] = bus.src_data[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_rr (
        .i_req  (bus.req),
        .i_last (r_last),
        .i_excl ('0),
        .o_idx  (w_win),
        .o_any  (w_any)
    );

    assign w_fsel_ok = {1'b0, bus.force_sel} < LP_NSRC;
    assign w_others  = |(bus.req & ~r_grant);
    assign w_preempt = (MAX_HOLD != 0) && (r_hold >= LP_HMAX)
                     && w_others;
    assign w_keep    = (r_state == OWNED) && bus.req[r_idx]
                     && (!w_preempt || bus.lock);

    always_comb begin
        w_state = IDLE;
        w_bus   = '0;
        w_valid = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        w_hold  = r_hold;
        w_last  = r_last;
        priority case (1'b1)
            bus.force_en: begin
                w_state = FORCED;
                if (w_fsel_ok) begin
                    w_grant = NSRC'(1) << bus.force_sel;
                    w_idx   = bus.force_sel;
                    w_bus   = w_src[bus.force_sel];
                    w_valid = 1'b1;
                end
            end
            w_keep: begin
                w_state = OWNED;
                w_grant = r_grant;
                w_idx   = r_idx;
                w_bus   = w_src[r_idx];
                w_valid = 1'b1;
                w_hold  = (r_hold == LP_HSAT) ? r_hold
                                              : r_hold + 1'b1;
            end
            w_any: begin
                w_state = OWNED;
                w_grant = NSRC'(1) << w_win;
                w_idx   = w_win;
                w_bus   = w_src[w_win];
                w_valid = 1'b1;
                w_hold  = HCW'(1);
                w_last  = w_win;
            end
            default: begin
                w_hold = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= IDLE;
            r_bus   <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
            r_idx   <= '0;
            r_hold  <= '0;
            r_last  <= SELW'(NSRC - 1);
        end else begin
            r_state <= w_state;
            r_bus   <= w_bus;
            r_valid <= w_valid;
            r_grant <= w_grant;
            r_idx   <= w_idx;
            r_hold  <= w_hold;
            r_last  <= w_last;
        end
    end

    assign bus.bus_out   = r_bus;
    assign bus.bus_valid = r_valid;
    assign bus.grant     = r_grant;
    assign bus.grant_idx = r_idx;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: reference model feeds a scoreboard queue,
// plus directed checks of round-robin, lock, handover, force and clear.
module tb_bus_arbiter_mux;
    import bus_pkg::*;

    localparam int W  = 32;
    localparam int N  = 26;
    localparam int SW = 5;
    localparam int MH = 8;

    typedef struct {
        logic [W-1:0] bus;
        logic         valid;
        logic [SW-1:0] idx;
        logic [N-1:0] grant;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [W-1:0]  src [N];
    logic [N-1:0]  req = '0;
    logic          lock = 1'b0;
    logic          fen = 1'b0;
    logic [SW-1:0] fsel = '0;

    int n_chk = 0;
    int n_err = 0;

    exp_t sbq[$];

    int           m_state;
    int           m_owner;
    int           m_last;
    int           m_hold;
    logic [W-1:0] m_bus;
    logic         m_valid;

    bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N)) bif ();

    bus_arbiter_mux #(
        .WIDTH    (W),
        .NSRC     (N),
        .MAX_HOLD (MH)
    ) dut (
        .clock   (clk),
        .clear_n (rst_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    always_comb begin
        bif.src_data = '0;
        for (int i = 0; i < N; i++) bif.src_data[i*W +: W] = src[i];
    end
    assign bif.req       = req;
    assign bif.lock      = lock;
    assign bif.force_en  = fen;
    assign bif.force_sel = fsel;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_owner = 0;
        m_last  = N - 1;
        m_hold  = 0;
        m_bus   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit others;
        bit keep;
        int w;
        int j;
        if (fen) begin
            m_state = 2;
            if (int'(fsel) < N) begin
                m_owner = int'(fsel);
                m_bus   = src[m_owner];
                m_valid = 1'b1;
            end else begin
                m_owner = 0;
                m_bus   = '0;
                m_valid = 1'b0;
            end
            return;
        end
        others = 0;
        for (int i = 0; i < N; i++)
            if (i != m_owner && req[i]) others = 1;
        keep = (m_state == 1) && req[m_owner]
            && (lock || !(MH > 0 && m_hold >= MH && others));
        if (keep) begin
            m_bus  = src[m_owner];
            m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
            return;
        end
        w = -1;
        for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (w < 0 && req[j]) w = j;
        end
        if (w >= 0) begin
            m_state = 1;
            m_owner = w;
            m_bus   = src[w];
            m_valid = 1'b1;
            m_hold  = 1;
            m_last  = w;
        end else begin
            m_state = 0;
            m_owner = 0;
            m_bus   = '0;
            m_valid = 1'b0;
            m_hold  = 0;
        end
    endtask

    task automatic cycle();
        exp_t e;
        exp_t g;
        model_step();
        e.bus   = m_bus;
        e.valid = m_valid;
        e.idx   = m_valid ? SW'(m_owner) : '0;
        e.grant = m_valid ? (N'(1) << m_owner) : '0;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        check("sb_bus", bif.bus_out, g.bus);
        check("sb_valid", 32'(bif.bus_valid), 32'(g.valid));
        check("sb_idx", 32'(bif.grant_idx), 32'(g.idx));
        check("sb_grant", 32'(bif.grant), 32'(g.grant));
        @(negedge clk);
    endtask

    task automatic rand_src();
        for (int i = 0; i < N; i++) src[i] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) src[i] = 32'h1000_0000 + 32'(i);
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_bus", bif.bus_out, 32'h0);
        check("rst_valid", 32'(bif.bus_valid), 32'h0);
        check("rst_grant", 32'(bif.grant), 32'h0);
        check("rst_idx", 32'(bif.grant_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        req = '0;
        cycle();
        cycle();

        // All sources requesting: each holds for MH cycles in turn.
        for (int n = 0; n < (N + 1) * MH; n++) begin
            rand_src();
            req = '1;
            cycle();
            check("rr_seq", 32'(bif.grant_idx), 32'((n / MH) % N));
            check("rr_valid", 32'(bif.bus_valid), 32'h1);
        end

        req = '0;
        cycle();
        check("idle_valid", 32'(bif.bus_valid), 32'h0);
        src[3] = 32'hDEAD_BEEF;
        req = N'(1) << 3;
        cycle();
        check("first_idx", 32'(bif.grant_idx), 32'd3);
        check("first_bus", bif.bus_out, 32'hDEAD_BEEF);
        check("first_valid", 32'(bif.bus_valid), 32'h1);

        req = N'(1) << 5;
        cycle();
        check("lock_own", 32'(bif.grant_idx), 32'd5);
        lock = 1'b1;
        req = (N'(1) << 5) | (N'(1) << 6);
        for (int n = 0; n < 20; n++) begin
            src[5] = $urandom;
            cycle();
            check("lock_hold", 32'(bif.grant_idx), 32'd5);
            check("lock_bus", bif.bus_out, src[5]);
        end
        lock = 1'b0;
        cycle();
        check("lock_drop", 32'(bif.grant_idx), 32'd6);

        req = N'(1) << 2;
        cycle();
        cycle();
        check("ho_own", 32'(bif.grant_idx), 32'd2);
        req = N'(1) << 7;
        cycle();
        check("ho_idx", 32'(bif.grant_idx), 32'd7);
        check("ho_valid", 32'(bif.bus_valid), 32'h1);

        req = N'(1) << 4;
        cycle();
        check("f_own", 32'(bif.grant_idx), 32'd4);
        src[PC] = 32'h0000_0100;
        fen = 1'b1;
        fsel = SW'(PC);
        cycle();
        check("f_bus", bif.bus_out, 32'h100);
        check("f_idx", 32'(bif.grant_idx), 32'd20);
        fsel = 5'd30;
        cycle();
        check("f_oor_valid", 32'(bif.bus_valid), 32'h0);
        check("f_oor_bus", bif.bus_out, 32'h0);
        fen = 1'b0;
        cycle();
        check("f_rel", 32'(bif.grant_idx), 32'd4);

        // Force and an owner change on the same edge: force wins.
        req = N'(1) << 9;
        fen = 1'b1;
        fsel = 5'd1;
        cycle();
        check("f_win", 32'(bif.grant_idx), 32'd1);
        fen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            check("solo_hold", 32'(bif.grant_idx), 32'd9);
        end

        #2;
        rst_n = 1'b0;
        #1;
        check("clr_bus", bif.bus_out, 32'h0);
        check("clr_grant", 32'(bif.grant), 32'h0);
        check("clr_valid", 32'(bif.bus_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = (N'(1) << 9) | (N'(1) << 17) | (N'(1) << 3);
        cycle();
        check("clr_first", 32'(bif.grant_idx), 32'd3);

        for (int n = 0; n < 200; n++) begin
            rand_src();
            req  = N'($urandom & $urandom & $urandom);
            lock = ($urandom_range(0, 3) == 0);
            fen  = ($urandom_range(0, 7) == 0);
            fsel = SW'($urandom_range(0, 31));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
